// File: rtl/stream_dmux_pkg.sv
// rtl/stream_dmux_pkg.sv - shared occupancy encoding and default widths for stream_dmux
package stream_dmux_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/stream_dmux_if.sv
// rtl/stream_dmux_if.sv - producer stream plus two consumer channels of stream_dmux
interface stream_dmux_if
  import stream_dmux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             sel;
  logic             a_valid;
  logic             a_ready;
  logic [W-1:0]     a_data;
  logic             b_valid;
  logic             b_ready;
  logic [W-1:0]     b_data;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport master (
    output in_valid, in_data, sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

endinterface

// File: rtl/dmux_chan_buf.sv
// rtl/dmux_chan_buf.sv - 2-entry FIFO buffer with occupancy FSM and delivered-beat counter
module dmux_chan_buf
  import stream_dmux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  occ_e             occ_q, occ_d;
  logic [W-1:0]     head_q, head_d;
  logic [W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // head_q is always the oldest beat, so output data comes straight from a flop
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    pop    = (occ_q != OCC_EMPTY) && ready;
    cnt_d  = pop ? cnt_q + CNT_ONE : cnt_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d  = OCC_ONE;
          head_d = push_data;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign full  = (occ_q == OCC_TWO);
  assign valid = (occ_q != OCC_EMPTY);
  assign data  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/stream_dmux.sv
// rtl/stream_dmux.sv - routes one valid/ready stream to channel a or b through registered 2-entry buffers
module stream_dmux
  import stream_dmux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  stream_dmux_if.slave bus
);

  logic full_a, full_b;
  logic push_a, push_b;
  logic accept;

  // in_ready looks only at registered fullness of the selected channel, never at a_ready/b_ready
  always_comb begin
    bus.in_ready = bus.sel ? !full_b : !full_a;
    accept       = bus.in_valid && bus.in_ready;
    push_a       = accept && !bus.sel;
    push_b       = accept && bus.sel;
  end

  dmux_chan_buf #(.W(W), .CNT_W(CNT_W)) u_chan_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .push_data (bus.in_data),
    .full      (full_a),
    .valid     (bus.a_valid),
    .ready     (bus.a_ready),
    .data      (bus.a_data),
    .count     (bus.a_count)
  );

  dmux_chan_buf #(.W(W), .CNT_W(CNT_W)) u_chan_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data (bus.in_data),
    .full      (full_b),
    .valid     (bus.b_valid),
    .ready     (bus.b_ready),
    .data      (bus.b_data),
    .count     (bus.b_count)
  );

endmodule

// File: tb/tb_stream_dmux.sv
// tb/tb_stream_dmux.sv - directed scoreboard bench for stream_dmux, plus a CNT_W=4 copy for counter wrap
module tb_stream_dmux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  stream_dmux_if #(.W(8), .CNT_W(16)) bus ();
  stream_dmux_if #(.W(8), .CNT_W(4))  busw ();

  stream_dmux #(.W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stream_dmux #(.W(8), .CNT_W(4)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (busw)
  );

  assign busw.in_valid = bus.in_valid;
  assign busw.in_data  = bus.in_data;
  assign busw.sel      = bus.sel;
  assign busw.a_ready  = bus.a_ready;
  assign busw.b_ready  = bus.b_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.a_valid === 1'b1 && bus.a_ready === 1'b1) begin
      if (exp_a.size() == 0) check("a_unexpected_beat", {24'd0, bus.a_data}, 32'hFFFF_FFFF);
      else check("a_data_order", {24'd0, bus.a_data}, {24'd0, exp_a.pop_front()});
    end
    if (!reset && bus.b_valid === 1'b1 && bus.b_ready === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_beat", {24'd0, bus.b_data}, 32'hFFFF_FFFF);
      else check("b_data_order", {24'd0, bus.b_data}, {24'd0, exp_b.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic drive_beat(input logic [7:0] d, input logic s, input int max_wait);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sel      = s;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready === 1'b1) begin
      if (s) exp_b.push_back(d);
      else   exp_a.push_back(d);
    end else begin
      check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic stream_beats(input int n, input logic alternate, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(i);
      bus.sel      = alternate ? i[0] : 1'b1;
      @(negedge clk);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (bus.sel) exp_b.push_back(bus.in_data);
      else         exp_a.push_back(bus.in_data);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.sel      = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;

    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
    check("rst_a_count", {16'd0, bus.a_count}, 32'd0);
    check("rst_b_count", {16'd0, bus.b_count}, 32'd0);
    check("rst_a_data", {24'd0, bus.a_data}, 32'd0);
    check("rst_in_ready_sel0", {31'd0, bus.in_ready}, 32'd1);
    bus.sel = 1'b1;
    #1;
    check("rst_in_ready_sel1", {31'd0, bus.in_ready}, 32'd1);
    step();

    // 2: single routing
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    drive_beat(8'h5A, 1'b0, 20);
    @(negedge clk);
    check("single_a_valid", {31'd0, bus.a_valid}, 32'd1);
    check("single_a_data", {24'd0, bus.a_data}, 32'h5A);
    check("single_b_idle_valid", {31'd0, bus.b_valid}, 32'd0);
    check("single_b_idle_data", {24'd0, bus.b_data}, 32'd0);
    step();
    drive_beat(8'hA5, 1'b1, 20);
    @(negedge clk);
    check("single_b_valid", {31'd0, bus.b_valid}, 32'd1);
    check("single_b_data", {24'd0, bus.b_data}, 32'hA5);
    step();
    step();
    @(negedge clk);
    check("single_a_count", {16'd0, bus.a_count}, 32'd1);
    check("single_b_count", {16'd0, bus.b_count}, 32'd1);
    step();

    // 3: backpressure fills a
    bus.a_ready = 1'b0;
    drive_beat(8'h01, 1'b0, 20);
    drive_beat(8'h02, 1'b0, 20);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    bus.sel      = 1'b0;
    @(negedge clk);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_a_valid", {31'd0, bus.a_valid}, 32'd1);
    check("full_a_data", {24'd0, bus.a_data}, 32'h01);
    step();
    @(negedge clk);
    check("full_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_hold_a_data", {24'd0, bus.a_data}, 32'h01);
    step();

    // 4: full a does not block a beat for b
    bus.in_data = 8'h44;
    bus.sel     = 1'b1;
    @(negedge clk);
    check("nonblock_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_b.push_back(8'h44);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("nonblock_b_valid", {31'd0, bus.b_valid}, 32'd1);
    check("nonblock_b_data", {24'd0, bus.b_data}, 32'h44);
    check("nonblock_a_valid", {31'd0, bus.a_valid}, 32'd1);
    check("nonblock_a_data", {24'd0, bus.a_data}, 32'h01);
    step();
    bus.a_ready = 1'b1;
    drive_beat(8'h03, 1'b0, 20);
    repeat (4) step();
    @(negedge clk);
    check("drain_a_count", {16'd0, bus.a_count}, 32'd4);
    check("drain_b_count", {16'd0, bus.b_count}, 32'd2);
    check("drain_a_queue", exp_a.size(), 32'd0);
    check("drain_b_queue", exp_b.size(), 32'd0);
    step();

    // 5: 100 back-to-back beats alternating channels
    stream_beats(100, 1'b1, 8'h10);
    repeat (3) step();
    @(negedge clk);
    check("stream_a_count", {16'd0, bus.a_count}, 32'd54);
    check("stream_b_count", {16'd0, bus.b_count}, 32'd52);
    check("stream_a_queue", exp_a.size(), 32'd0);
    check("stream_b_queue", exp_b.size(), 32'd0);
    step();

    // 6: asynchronous reset with a holding two beats, then counter wrap
    bus.a_ready = 1'b0;
    drive_beat(8'hE1, 1'b0, 20);
    drive_beat(8'hE2, 1'b0, 20);
    @(negedge clk);
    check("pre_reset_a_valid", {31'd0, bus.a_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_a_valid", {31'd0, bus.a_valid}, 32'd0);
    check("async_reset_a_count", {16'd0, bus.a_count}, 32'd0);
    check("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.b_ready = 1'b1;
    stream_beats(17, 1'b0, 8'h80);
    repeat (3) step();
    @(negedge clk);
    check("wrap_b_count_w16", {16'd0, bus.b_count}, 32'd17);
    check("wrap_b_count_w4", {28'd0, busw.b_count}, 32'd1);
    check("wrap_a_count_w4", {28'd0, busw.a_count}, 32'd0);
    check("wrap_b_queue", exp_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
